// File: rtl/spm_seq.sv
// Sequential unsigned multiplier: feeds the multiplicand LSB-first into a
// carry-save serial/parallel core and collects the 2*BITS-bit product serially.

module spm #(
    parameter int bits = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tm,
    input  logic            sce,
    input  logic            sci,
    input  logic            x,
    input  logic [bits-1:0] a,
    output logic            y,
    output logic            sco
);

    logic [bits-1:0] s_q;
    logic [bits-1:0] s_d;
    logic [bits-1:0] c_q;
    logic [bits-1:0] c_d;
    logic [bits-1:0] pp_s;
    logic [bits-1:0] up_s;

    // Each stage adds its partial-product bit, the sum from the stage above and
    // its own carry, so stage 0 emits one finished product bit per edge.
    always_comb begin
        pp_s = a & {bits{x}};
        up_s = {1'b0, s_q[bits-1:1]};
        s_d  = s_q;
        c_d  = c_q;
        if (tm && sce) begin
            {c_d, s_d} = {sci, c_q, s_q[bits-1:1]};
        end else begin
            s_d = pp_s ^ up_s ^ c_q;
            c_d = (pp_s & up_s) | (pp_s & c_q) | (up_s & c_q);
        end
    end

    // Sum and carry registers of the adder chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q <= '0;
            c_q <= '0;
        end else begin
            s_q <= s_d;
            c_q <= c_d;
        end
    end

    assign y   = s_q[0];
    assign sco = s_q[0];

endmodule

module spm_seq #(
    parameter int BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BITS-1:0]   mc,
    input  logic [BITS-1:0]   mp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*BITS-1:0] prod,
    output logic              busy
);

    localparam int             CW       = $clog2(2 * BITS + 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(BITS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(2 * BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [BITS-1:0]     a_reg_q;
    logic [BITS-1:0]     a_reg_d;
    logic [BITS-1:0]     xsh_q;
    logic [BITS-1:0]     xsh_d;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic [2*BITS-1:0]   prod_q;
    logic [2*BITS-1:0]   prod_d;
    logic                in_ready_q;
    logic                in_ready_d;
    logic                out_valid_q;
    logic                out_valid_d;
    logic                busy_q;
    logic                busy_d;
    logic                x_s;
    logic                y_s;

    spm #(
        .bits (BITS)
    ) u_spm (
        .clk (clk),
        .rst (rst),
        .tm  (1'b0),
        .sce (1'b0),
        .sci (1'b0),
        .x   (x_s),
        .y   (y_s),
        .a   (a_reg_q),
        .sco ()
    );

    // Serial multiplicand bit; zeros outside the first BITS run cycles flush the core.
    always_comb begin
        x_s = 1'b0;
        if ((state_q == RUN) && (cnt_q < CNT_HALF)) begin
            x_s = xsh_q[0];
        end else begin
            x_s = 1'b0;
        end
    end

    // Next-state and datapath updates; handshake outputs follow the next state.
    always_comb begin
        state_d = state_q;
        a_reg_d = a_reg_q;
        xsh_d   = xsh_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_reg_d = mp;
                    xsh_d   = mc;
                    cnt_d   = '0;
                    prod_d  = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q < CNT_HALF) begin
                    xsh_d = {1'b0, xsh_q[BITS-1:1]};
                end else begin
                    xsh_d = xsh_q;
                end
                // The core output lags x by one edge, so the first capture is at cnt==1.
                if (cnt_q != '0) begin
                    prod_d = {y_s, prod_q[2*BITS-1:1]};
                end else begin
                    prod_d = prod_q;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d == RUN);
        out_valid_d = (state_d == DONE);
    end

    // State, datapath and registered handshake flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_reg_q     <= '0;
            xsh_q       <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_reg_q     <= a_reg_d;
            xsh_q       <= xsh_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign prod      = prod_q;

endmodule
